pipe_perf_monitor: RTL and testbench

- Synthesizable run-time performance and health monitor for the pipelined core.
- Counts cycles, retired instructions, control-transfer instructions and mispredictions over a programmable measurement window.
- Watches for a hung pipeline and exposes all counters through a registered read port.
- Sits beside the core, fed by its debug outputs (o_insn_vld, o_ctrl, o_mispred, o_pc_debug); it is the in-silicon successor to fixed testbench timeout/scoreboard checking.

---
 rtl/pipe_perf_monitor_pkg.sv | 15 +
 rtl/pipe_perf_monitor_if.sv | 32 +++
 rtl/pipe_perf_monitor_sat_counter.sv | 28 ++
 rtl/pipe_perf_monitor.sv | 112 +++++++++++
 tb/tb_pipe_perf_monitor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_perf_monitor_pkg.sv
// perf_pkg: shared FSM encoding, read-select codes and overflow flag bit positions
package perf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [2:0] SEL_CYC    = 3'd0;
    localparam logic [2:0] SEL_INSN   = 3'd1;
    localparam logic [2:0] SEL_CTRL   = 3'd2;
    localparam logic [2:0] SEL_MISP   = 3'd3;
    localparam logic [2:0] SEL_STREAK = 3'd4;
    localparam logic [2:0] SEL_STAT   = 3'd5;
    localparam logic [2:0] SEL_PC     = 3'd6;
    localparam int OVF_CYC  = 0;
    localparam int OVF_INSN = 1;
    localparam int OVF_CTRL = 2;
    localparam int OVF_MISP = 3;
endpackage

// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_monitor_if: core debug feed, measurement control and read port of the perf monitor
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 16,
    parameter int PC_W  = 32
);
    logic             i_insn_vld;
    logic             i_ctrl;
    logic             i_mispred;
    logic [PC_W-1:0]  i_pc_debug;
    logic             i_start;
    logic             i_stop;
    logic             i_clear;
    logic [WIN_W-1:0] i_win_len;
    logic             i_rd_req;
    logic [2:0]       i_rd_sel;
    logic [CNT_W-1:0] o_rd_data;
    logic             o_rd_vld;
    logic             o_busy;
    logic             o_win_done;
    logic             o_hang;
    logic [PC_W-1:0]  o_last_pc;
    logic [3:0]       o_ovf;
    modport master (
        output i_insn_vld, i_ctrl, i_mispred, i_pc_debug, i_start, i_stop, i_clear, i_win_len, i_rd_req, i_rd_sel,
        input  o_rd_data, o_rd_vld, o_busy, o_win_done, o_hang, o_last_pc, o_ovf
    );
    modport slave (
        input  i_insn_vld, i_ctrl, i_mispred, i_pc_debug, i_start, i_stop, i_clear, i_win_len, i_rd_req, i_rd_sel,
        output o_rd_data, o_rd_vld, o_busy, o_win_done, o_hang, o_last_pc, o_ovf
    );
endinterface

// File: rtl/pipe_perf_monitor_sat_counter.sv
// perf_sat_counter: saturating up-counter with a sticky overflow flag
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);
    logic [W-1:0] cnt_q;
    logic         ovf_q;
    logic         at_max;
    assign at_max = &cnt_q;
    assign o_cnt  = cnt_q;
    assign o_ovf  = ovf_q;
    // clear beats increment; an increment at full scale holds the count and raises the flag
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (i_inc) begin
            cnt_q <= at_max ? cnt_q : cnt_q + 1'b1;
            ovf_q <= ovf_q | at_max;
        end
    end
endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: windowed cycle/retire/branch/mispredict counters with hang watch; PERF_STREAK_EN adds max correct-prediction streak
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 16,
    parameter int HANG_CYCLES = 1024,
    parameter int PC_W        = 32
) (
    input logic                i_clk,
    input logic                i_reset,
    pipe_perf_monitor_if.slave bus
);
    localparam int HW = $clog2(HANG_CYCLES + 1);
    localparam int MW = (CNT_W > WIN_W ? CNT_W : WIN_W) + 1;
    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_len_q;
    logic [HW-1:0]    hang_cnt_q;
    logic             hang_q, win_done_q, rd_vld_q;
    logic [PC_W-1:0]  last_pc_q;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] cyc, insn, ctrl, misp, streak_max;
    logic [3:0]       ovf;
    logic             run, start_acc, clr_all, cnt_en, ev_insn, ev_ctrl, ev_misp, win_hit;
    assign run       = state_q == RUN;
    assign start_acc = !bus.i_clear && !run && bus.i_start;
    assign clr_all   = bus.i_clear || start_acc;
    assign cnt_en    = run && !bus.i_clear && !bus.i_stop;
    assign ev_insn   = cnt_en && bus.i_insn_vld;
    assign ev_ctrl   = ev_insn && bus.i_ctrl;
    assign ev_misp   = ev_ctrl && bus.i_mispred;
    assign win_hit   = cnt_en && win_len_q != '0 && MW'(cyc) + MW'(1) == MW'(win_len_q);
    perf_sat_counter #(.W(CNT_W)) u_cyc  (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all), .i_inc(cnt_en),  .o_cnt(cyc),  .o_ovf(ovf[OVF_CYC]));
    perf_sat_counter #(.W(CNT_W)) u_insn (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all), .i_inc(ev_insn), .o_cnt(insn), .o_ovf(ovf[OVF_INSN]));
    perf_sat_counter #(.W(CNT_W)) u_ctrl (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all), .i_inc(ev_ctrl), .o_cnt(ctrl), .o_ovf(ovf[OVF_CTRL]));
    perf_sat_counter #(.W(CNT_W)) u_misp (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all), .i_inc(ev_misp), .o_cnt(misp), .o_ovf(ovf[OVF_MISP]));
`ifdef PERF_STREAK_EN
    logic [CNT_W-1:0] streak_run;
    logic             streak_inc, run_ovf_unused, max_ovf_unused;
    assign streak_inc = ev_ctrl && !bus.i_mispred;
    perf_sat_counter #(.W(CNT_W)) u_streak_run (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all || ev_misp), .i_inc(streak_inc),
                                                .o_cnt(streak_run), .o_ovf(run_ovf_unused));
    // the running streak climbs by one, so the max moves only while the two are equal
    perf_sat_counter #(.W(CNT_W)) u_streak_max (.i_clk(i_clk), .i_reset(i_reset), .i_clr(clr_all),
                                                .i_inc(streak_inc && streak_run == streak_max),
                                                .o_cnt(streak_max), .o_ovf(max_ovf_unused));
`else
    assign streak_max = '0;
`endif
    // next state: clear beats stop beats start; stop or window expiry end a run
    always_comb begin
        state_d = state_q;
        if (bus.i_clear) state_d = IDLE;
        else if (start_acc) state_d = RUN;
        else if (run && (bus.i_stop || win_hit)) state_d = DONE;
    end
    // state, window length, hang watch, last retired PC and expiry pulse
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            win_len_q  <= '0;
            hang_cnt_q <= '0;
            hang_q     <= 1'b0;
            win_done_q <= 1'b0;
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_done_q <= win_hit;
            if (start_acc) win_len_q <= bus.i_win_len;
            if (clr_all) begin
                hang_cnt_q <= '0;
                hang_q     <= 1'b0;
            end else if (cnt_en) begin
                hang_cnt_q <= bus.i_insn_vld ? '0 : hang_cnt_q == HW'(HANG_CYCLES) ? hang_cnt_q : hang_cnt_q + 1'b1;
                hang_q     <= hang_q | (!bus.i_insn_vld && hang_cnt_q == HW'(HANG_CYCLES - 1));
            end
            if (bus.i_clear) last_pc_q <= '0;
            else if (ev_insn) last_pc_q <= bus.i_pc_debug;
        end
    end
    // read mux over register contents before the sampling edge
    always_comb begin
        rd_data_d = '0;
        case (bus.i_rd_sel)
            SEL_CYC:    rd_data_d = cyc;
            SEL_INSN:   rd_data_d = insn;
            SEL_CTRL:   rd_data_d = ctrl;
            SEL_MISP:   rd_data_d = misp;
            SEL_STREAK: rd_data_d = streak_max;
            SEL_STAT:   rd_data_d = CNT_W'({hang_q, ovf});
            SEL_PC:     rd_data_d = CNT_W'(last_pc_q);
            default:    rd_data_d = '0;
        endcase
    end
    // registered read port: one result per request, data held between reads
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= bus.i_rd_req;
            if (bus.i_rd_req) rd_data_q <= rd_data_d;
        end
    end
    assign bus.o_rd_data  = rd_data_q;
    assign bus.o_rd_vld   = rd_vld_q;
    assign bus.o_busy     = run;
    assign bus.o_win_done = win_done_q;
    assign bus.o_hang     = hang_q;
    assign bus.o_last_pc  = last_pc_q;
    assign bus.o_ovf      = ovf;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: scoreboard bench; a 32-bit instance is tracked by a cycle model, a 4-bit instance checks saturation
module tb_pipe_perf_monitor;
    localparam int HC = 8;
`ifdef PERF_STREAK_EN
    localparam logic [31:0] STREAK_EXP = 32'd6;
`else
    localparam logic [31:0] STREAK_EXP = 32'd0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pipe_perf_monitor_if #(.CNT_W(32), .WIN_W(16), .PC_W(32)) ifa ();
    pipe_perf_monitor_if #(.CNT_W(4),  .WIN_W(16), .PC_W(32)) ifb ();
    pipe_perf_monitor #(.CNT_W(32), .WIN_W(16), .HANG_CYCLES(HC), .PC_W(32)) u_dut (.i_clk(clk), .i_reset(rst_n), .bus(ifa.slave));
    pipe_perf_monitor #(.CNT_W(4),  .WIN_W(16), .HANG_CYCLES(HC), .PC_W(32)) u_sat (.i_clk(clk), .i_reset(rst_n), .bus(ifb.slave));
    assign ifb.i_insn_vld = ifa.i_insn_vld;
    assign ifb.i_ctrl     = ifa.i_ctrl;
    assign ifb.i_mispred  = ifa.i_mispred;
    assign ifb.i_pc_debug = ifa.i_pc_debug;
    assign ifb.i_start    = ifa.i_start;
    assign ifb.i_stop     = ifa.i_stop;
    assign ifb.i_clear    = ifa.i_clear;
    assign ifb.i_win_len  = ifa.i_win_len;
    assign ifb.i_rd_req   = ifa.i_rd_req;
    assign ifb.i_rd_sel   = ifa.i_rd_sel;
    int errs = 0;
    int checks = 0;
    logic [31:0] sb_q[$];
    int          m_st;
    int unsigned m_cyc, m_insn, m_ctrl, m_misp, m_hc, m_wl;
    logic        m_hang, m_wd;
    logic [31:0] m_pc;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // advance the model by one edge from the current inputs, clock the DUT, then compare status outputs
    task automatic step();
        if (!rst_n) begin
            m_st = 0; m_cyc = 0; m_insn = 0; m_ctrl = 0; m_misp = 0; m_hc = 0; m_wl = 0;
            m_hang = 0; m_wd = 0; m_pc = 0;
        end else begin
            m_wd = 0;
            if (ifa.i_clear) begin
                m_st = 0; m_cyc = 0; m_insn = 0; m_ctrl = 0; m_misp = 0; m_hc = 0; m_hang = 0; m_pc = 0;
            end else if (m_st != 1) begin
                if (ifa.i_start) begin
                    m_st = 1; m_cyc = 0; m_insn = 0; m_ctrl = 0; m_misp = 0; m_hc = 0; m_hang = 0;
                    m_wl = ifa.i_win_len;
                end
            end else if (ifa.i_stop) begin
                m_st = 2;
            end else begin
                m_cyc++;
                if (ifa.i_insn_vld) begin
                    m_insn++;
                    m_pc = ifa.i_pc_debug;
                    m_hc = 0;
                    if (ifa.i_ctrl) m_ctrl++;
                    if (ifa.i_ctrl && ifa.i_mispred) m_misp++;
                end else begin
                    if (m_hc < HC) m_hc++;
                    if (m_hc == HC) m_hang = 1;
                end
                if (m_wl != 0 && m_cyc == m_wl) begin
                    m_st = 2;
                    m_wd = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("busy", ifa.o_busy, m_st == 1);
        check("win_done", ifa.o_win_done, m_wd);
        check("hang", ifa.o_hang, m_hang);
        check("last_pc", ifa.o_last_pc, m_pc);
        check("ovf32", ifa.o_ovf, 0);
    endtask
    task automatic drv(input logic vld, input logic ctl, input logic mis);
        ifa.i_insn_vld = vld;
        ifa.i_ctrl     = ctl;
        ifa.i_mispred  = mis;
        ifa.i_pc_debug = $urandom;
    endtask
    task automatic rd(input logic [2:0] sel, input logic [31:0] exp);
        ifa.i_rd_req = 1'b1;
        ifa.i_rd_sel = sel;
        sb_q.push_back(exp);
        step();
        ifa.i_rd_req = 1'b0;
    endtask
    task automatic cmd_start(input logic [15:0] wl);
        ifa.i_win_len = wl;
        ifa.i_start   = 1'b1;
        step();
        ifa.i_start   = 1'b0;
        ifa.i_win_len = '0;
    endtask
    task automatic cmd_stop();
        ifa.i_stop = 1'b1;
        step();
        ifa.i_stop = 1'b0;
    endtask
    task automatic cmd_clear();
        ifa.i_clear = 1'b1;
        step();
        ifa.i_clear = 1'b0;
    endtask
    // read-response side of the scoreboard
    always @(negedge clk) begin
        if (ifa.o_rd_vld) begin
            if (sb_q.size() == 0) check("rd_unexpected", ifa.o_rd_vld, 0);
            else check("rd_data", ifa.o_rd_data, sb_q.pop_front());
        end
    end
    initial begin
        drv(0, 0, 0);
        ifa.i_start = 0; ifa.i_stop = 0; ifa.i_clear = 0; ifa.i_win_len = 0; ifa.i_rd_req = 0; ifa.i_rd_sel = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_rd_vld", ifa.o_rd_vld, 0);
        check("rst_rd_data", ifa.o_rd_data, 0);
        rd(0, 0);
        // window of 20 cycles
        cmd_start(16'd20);
        for (int i = 0; i < 20; i++) begin
            drv(1, i % 4 == 3, i == 7 || i == 15);
            step();
            if (i == 18) check("win_not_yet", ifa.o_win_done, 0);
        end
        check("win_pulse", ifa.o_win_done, 1);
        check("win_done_state", ifa.o_busy, 0);
        drv(0, 0, 0);
        step();
        check("win_pulse_once", ifa.o_win_done, 0);
        rd(0, 20); rd(1, 20); rd(2, 5); rd(3, 2);
        // stop beats a simultaneous start
        cmd_start(16'd0);
        for (int i = 0; i < 10; i++) begin
            drv(1, 0, 0);
            step();
        end
        ifa.i_start = 1'b1;
        cmd_stop();
        ifa.i_start = 1'b0;
        drv(0, 0, 0);
        check("stop_no_restart", ifa.o_busy, 0);
        step();
        rd(0, 10); rd(1, 10); rd(2, 0);
        cmd_start(16'd0);
        rd(0, 0);
        rd(0, 1);
        cmd_stop();
        // hang detection
        cmd_start(16'd0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0);
            step();
        end
        drv(0, 0, 0);
        for (int i = 0; i < HC; i++) begin
            step();
            if (i == HC - 2) check("hang_early", ifa.o_hang, 0);
        end
        check("hang_set", ifa.o_hang, 1);
        step();
        drv(1, 0, 0);
        ifa.i_pc_debug = 32'hCAFE_0010;
        step();
        check("hang_sticky", ifa.o_hang, 1);
        cmd_stop();
        check("hang_in_done", ifa.o_hang, 1);
        rd(5, 32'h10); rd(6, 32'hCAFE_0010); rd(7, 0);
        cmd_clear();
        check("clear_hang", ifa.o_hang, 0);
        check("clear_pc", ifa.o_last_pc, 0);
        // back-to-back reads mid-run
        cmd_start(16'd0);
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0);
            step();
        end
        rd(1, 5); rd(1, 6); rd(1, 7);
        step();
        check("rd_vld_drop", ifa.o_rd_vld, 0);
        cmd_stop();
        cmd_clear();
        // saturation on the 4-bit instance
        cmd_start(16'd0);
        for (int i = 0; i < 20; i++) begin
            drv(1, 0, 0);
            step();
        end
        cmd_stop();
        check("sat_ovf", ifb.o_ovf, 32'h3);
        rd(0, 20);
        check("sat_cyc", ifb.o_rd_data, 15);
        rd(1, 20);
        check("sat_insn", ifb.o_rd_data, 15);
        rd(5, 0);
        check("sat_stat", ifb.o_rd_data, 3);
        cmd_clear();
        // reset in the middle of a windowed run
        cmd_start(16'd6);
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 0);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drv(0, 0, 0);
        check("rst_mid_busy", ifa.o_busy, 0);
        check("rst_mid_pc", ifa.o_last_pc, 0);
        check("rst_mid_rd_data", ifa.o_rd_data, 0);
        step();
        check("rst_mid_no_pulse", ifa.o_win_done, 0);
        rd(0, 0); rd(2, 0);
        // correct-prediction streak
        cmd_start(16'd0);
        for (int i = 0; i < 9; i++) begin
            drv(1, 1, i == 6);
            step();
        end
        cmd_stop();
        rd(4, STREAK_EXP); rd(2, 9); rd(3, 1);
        drv(0, 0, 0);
        step();
        step();
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
